// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between the producers, the round-robin arbiter and the FIFO write port.
// The master modport is the arbiter's view; the slave modport is the producers' and FIFO's view.
interface fifo_wr_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8
) ();
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    ack;
    logic [N_REQ-1:0]    grant;
    logic                fifo_full;
    logic                fifo_wr_en;
    logic [DW-1:0]       fifo_din;

    modport master (
        input  req,
        input  req_data,
        input  fifo_full,
        output ack,
        output grant,
        output fifo_wr_en,
        output fifo_din
    );

    modport slave (
        output req,
        output req_data,
        output fifo_full,
        input  ack,
        input  grant,
        input  fifo_wr_en,
        input  fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// One owner at a time, bounded bursts of MAX_BURST beats, stalls while the FIFO is full.
// Optional per-requester accepted-beat counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_wr_arbiter_if.master     bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]   beat_count
`endif
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    localparam logic [PtrW-1:0] LastIdx  = PtrW'(N_REQ - 1);
    localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

    logic [0:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PtrW-1:0]  owner_q, owner_d;
    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]  beat_cnt_q, beat_cnt_d;

    logic             pick_valid;
    logic [PtrW-1:0]  pick_idx;
    logic [PtrW-1:0]  cand_idx;
    logic             owner_req;
    logic [DW-1:0]    owner_data;
    logic             beat;

    // Round-robin search: scan downward so the candidate closest to rr_ptr is the last one kept.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_idx = PtrW'((32'(rr_ptr_q) + 32'(i)) % N_REQ);
            if (bus.req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign owner_req  = bus.req[owner_q];
    assign owner_data = bus.req_data[32'(owner_q) * DW +: DW];
    assign beat       = (state_q == StGrant) & owner_req & ~bus.fifo_full;

    // Write port and ack are combinational off the registered owner, so a full stall blocks same-cycle.
    always_comb begin
        bus.ack        = '0;
        bus.fifo_wr_en = beat;
        bus.fifo_din   = '0;
        if (state_q == StGrant) begin
            bus.fifo_din = owner_data;
            if (beat) begin
                bus.ack[owner_q] = 1'b1;
            end
        end
    end

    assign bus.grant = grant_q;

    // Arbitration and burst bookkeeping.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d           = StGrant;
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    beat_cnt_d        = '0;
                end
            end
            StGrant: begin
                // Release on dropped request or on the final beat of a full burst.
                if (!owner_req || (beat && (beat_cnt_q == LastBeat))) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    rr_ptr_d = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stat_q [N_REQ];

    // Per-requester accepted-beat counters; wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.ack[i]) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        beat_count = '0;
        for (int i = 0; i < N_REQ; i++) begin
            beat_count[i*16 +: 16] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized producers,
// all checked cycle by cycle against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned DW        = 8;
    localparam int unsigned MAX_BURST = 4;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
    logic [N_REQ*16-1:0] beat_count;
`endif

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .beat_count (beat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producer-side stimulus.
    logic [N_REQ-1:0] req_v;
    logic [DW-1:0]    data_v [N_REQ];
    logic             full_v;

    assign bus.req       = req_v;
    assign bus.fifo_full = full_v;

    always_comb begin
        bus.req_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_data[i*DW +: DW] = data_v[i];
        end
    end

    // Reference model: owner index (-1 = idle), round-robin start, beats in current burst.
    int               m_owner;
    int               m_ptr;
    int               m_cnt;
    logic [N_REQ-1:0] m_ack;
    int               stat_exp [N_REQ];

    int tests_run;
    int tests_failed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_ack   = '0;
        for (int i = 0; i < N_REQ; i++) stat_exp[i] = 0;
    endtask

    // One clock cycle: check DUT outputs mid-cycle against the model, then advance the model.
    task automatic run_cycle();
        logic [N_REQ-1:0] exp_grant;
        logic [N_REQ-1:0] exp_ack;
        logic             exp_wr;
        logic [DW-1:0]    exp_din;
        logic             beat;
        @(negedge clk);
        exp_grant = '0;
        exp_ack   = '0;
        exp_wr    = 1'b0;
        exp_din   = '0;
        beat      = 1'b0;
        if (m_owner >= 0) begin
            exp_grant[m_owner] = 1'b1;
            exp_din            = data_v[m_owner];
            beat               = req_v[m_owner] && !full_v;
            if (beat) begin
                exp_ack[m_owner] = 1'b1;
                exp_wr           = 1'b1;
            end
        end
        check_eq("grant", 32'(bus.grant), 32'(exp_grant));
        check_eq("ack", 32'(bus.ack), 32'(exp_ack));
        check_eq("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(exp_wr));
        check_eq("fifo_din", 32'(bus.fifo_din), 32'(exp_din));

        if (m_owner < 0) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (req_v[(m_ptr + k) % N_REQ]) m_owner = (m_ptr + k) % N_REQ;
            end
            m_cnt = 0;
        end else if (!req_v[m_owner] || (beat && (m_cnt + 1 == MAX_BURST))) begin
            m_ptr   = (m_owner + 1) % N_REQ;
            m_owner = -1;
        end else if (beat) begin
            m_cnt++;
        end
        m_ack = exp_ack;
        for (int i = 0; i < N_REQ; i++) if (exp_ack[i]) stat_exp[i]++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check_eq({tag, "_ack"}, 32'(bus.ack), 32'd0);
        check_eq({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
        check_eq({tag, "_din"}, 32'(bus.fifo_din), 32'd0);
    endtask

    int n_beats;
    int n_stall;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        req_v        = '0;
        full_v       = 1'b0;
        for (int i = 0; i < N_REQ; i++) data_v[i] = '0;
        model_reset();

        // Reset state, with a request already pending.
        req_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        req_v = '0;
        rst   = 1'b1;

        // Single long request on 0: 4-beat burst, one idle cycle, then the remaining 2 beats.
        req_v[0]  = 1'b1;
        data_v[0] = 8'h10;
        n_beats   = 0;
        for (int c = 0; c < 14; c++) begin
            run_cycle();
            if (m_ack[0]) begin
                n_beats++;
                if (data_v[0] == 8'h15) req_v[0] = 1'b0;
                else data_v[0] = data_v[0] + 8'd1;
            end
        end
        check_eq("single_burst_beats", 32'(n_beats), 32'd6);

        // Full stall on owner 2 after 2 beats for 5 cycles.
        req_v[2]  = 1'b1;
        data_v[2] = 8'h40;
        n_beats   = 0;
        n_stall   = 0;
        for (int c = 0; c < 18; c++) begin
            run_cycle();
            if (m_ack[2]) begin
                n_beats++;
                data_v[2] = data_v[2] + 8'd1;
                if (n_beats == 4) req_v[2] = 1'b0;
            end
            if (n_beats == 2 && n_stall < 5) begin
                full_v = 1'b1;
                n_stall++;
            end else begin
                full_v = 1'b0;
            end
        end
        check_eq("stall_beats", 32'(n_beats), 32'd4);

        // Early drop: owner 1 drops after one beat while 3 waits.
        req_v[1]  = 1'b1;
        data_v[1] = 8'h21;
        for (int c = 0; c < 10 && m_owner != 1; c++) run_cycle();
        req_v[3]  = 1'b1;
        data_v[3] = 8'h33;
        n_beats   = 0;
        for (int c = 0; c < 14; c++) begin
            run_cycle();
            if (m_ack[1]) req_v[1] = 1'b0;
            if (m_ack[3]) begin
                n_beats++;
                data_v[3] = data_v[3] + 8'd1;
                if (n_beats == 2) req_v[3] = 1'b0;
            end
        end
        check_eq("early_drop_req3_beats", 32'(n_beats), 32'd2);

        // Reset in the middle of a burst: outputs clear without a clock edge.
        req_v[0]  = 1'b1;
        data_v[0] = 8'h55;
        n_beats   = 0;
        for (int c = 0; c < 12 && n_beats < 1; c++) begin
            run_cycle();
            if (m_ack[0]) begin
                n_beats++;
                data_v[0] = data_v[0] + 8'd1;
            end
        end
        #2;
        check_eq("pre_reset_wr_en", 32'(bus.fifo_wr_en), 32'd1);
        rst = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            run_cycle();
            if (m_ack[0]) data_v[0] = data_v[0] + 8'd1;
        end
        req_v = '0;

        // Randomized producers and FIFO back-pressure.
        for (int c = 0; c < 3000; c++) begin
            run_cycle();
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_v[i]) begin
                    if ($urandom_range(2) == 0) begin
                        req_v[i]  = 1'b1;
                        data_v[i] = DW'($urandom);
                    end
                end else if (m_ack[i]) begin
                    if ($urandom_range(3) != 0) data_v[i] = DW'($urandom);
                    else req_v[i] = 1'b0;
                end else if ($urandom_range(19) == 0) begin
                    req_v[i] = 1'b0;
                end
            end
            full_v = ($urandom_range(3) == 0);
        end
        req_v  = '0;
        full_v = 1'b0;
        run_cycle();
        run_cycle();

`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < N_REQ; i++) begin
            check_eq($sformatf("beat_count%0d", i), 32'(beat_count[i*16 +: 16]),
                     32'(stat_exp[i] % 65536));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
